uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with configurable data width and parity mode, plus a first-word-fall-through RX FIFO.

---
 rtl/uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with configurable data width and parity, followed by a
//   first-word-fall-through RX FIFO. Framing, parity and overrun errors are
//   reported as single-cycle pulses.
//
// Parameters
//   SYS_CLK_FREQ / BAUD_RATE  clock-to-bit ratio (CLKS_PER_BIT, >= 4)
//   DATA_BITS                 data bits per character, 5..9
//   PARITY                    0 none, 1 odd, 2 even
//   FIFO_DEPTH                FIFO entries, power of 2, >= 2
//   TIMEOUT_BITS              idle bit-times before rx_timeout
//
// Ports
//   comm_clk    in   clock
//   rst_n       in   asynchronous active-low reset
//   rx_serial   in   asynchronous serial line, idle high
//   rx_data     out  FIFO head (0 while empty)
//   rx_valid    out  FIFO non-empty
//   rx_ready    in   pop head when rx_valid & rx_ready
//   fifo_count  out  occupancy, 0..FIFO_DEPTH
//   frame_err   out  pulse: stop bit sampled low
//   parity_err  out  pulse: parity mismatch with good stop bit
//   overrun     out  pulse: good character dropped because FIFO full
//   rx_timeout  out  pulse: idle timeout with data pending
//
// Build option
//   UART_RX_TIMEOUT_EN  enables the idle-timeout counter; otherwise rx_timeout is 0.

module uart_rx_fifo #(
    parameter int SYS_CLK_FREQ = 16,
    parameter int BAUD_RATE    = 1,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                          comm_clk,
    input  logic                          rst_n,
    input  logic                          rx_serial,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          rx_timeout
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam bit PARAMS_OK = (CLKS_PER_BIT >= 4) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                               (PARITY >= 0) && (PARITY <= 2) && (FIFO_DEPTH >= 2) &&
                               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) && (TIMEOUT_BITS >= 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HI
    } state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 sync1;
    logic                 rxs;
    state_t               state, state_next;
    logic [CW-1:0]        clk_cnt, clk_cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_bit_next;
    logic                 push_req, push_req_next;
    logic                 frame_err_next, parity_err_next;
    logic                 half_done, bit_done;
    logic                 ones_odd, par_bad;

    assign half_done = (clk_cnt == CW'(HALF_BIT - 1));
    assign bit_done  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign ones_odd  = (^shreg) ^ par_bit;
    assign par_bad   = (PARITY == 1) ? ~ones_odd :
                       (PARITY == 2) ?  ones_odd : 1'b0;

    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            push_req   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sync1      <= rx_serial;
            rxs        <= sync1;
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shreg      <= shreg_next;
            par_bit    <= par_bit_next;
            push_req   <= push_req_next;
            frame_err  <= frame_err_next;
            parity_err <= parity_err_next;
        end
    end

    always_comb begin
        state_next      = state;
        clk_cnt_next    = clk_cnt + 1'b1;
        bit_cnt_next    = bit_cnt;
        shreg_next      = shreg;
        par_bit_next    = par_bit;
        push_req_next   = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;

        unique case (state)
            S_IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                if (half_done) begin
                    clk_cnt_next = '0;
                    state_next   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    shreg_next   = {rxs, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    par_bit_next = rxs;
                    state_next   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (rxs) begin
                        state_next = S_IDLE;
                        if (par_bad) parity_err_next = 1'b1;
                        else         push_req_next   = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                clk_cnt_next = '0;
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // shreg is written straight into the FIFO on the push cycle: the next
    // character cannot shift into it until at least a bit-time later.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 full, do_pop, do_push;

    assign rx_valid = (fifo_count != '0);
    assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign do_pop   = rx_valid & rx_ready;
    assign do_push  = push_req & (~full | do_pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge comm_clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push_req & full & ~do_pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_clear, to_run;

    assign to_clear = ((state == S_IDLE) & ~rxs) | do_pop;
    assign to_run   = (state == S_IDLE) & rx_valid;

    // Counter saturates at the limit so the pulse fires only once per idle spell.
    always_ff @(posedge comm_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt     <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= 1'b0;
            if (to_clear) begin
                to_cnt <= '0;
            end else if (to_run && to_cnt != TW'(TO_LIMIT)) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TW'(TO_LIMIT - 1)) rx_timeout <= 1'b1;
            end
        end
    end
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n      = 1'b0;
    logic tx         = 1'b1;
    logic tx_sel     = 1'b0;
    logic rx_ready   = 1'b0;
    logic rx_ready_b = 1'b0;
    logic rx_a, rx_b;

    assign rx_a = tx_sel ? 1'b1 : tx;
    assign rx_b = tx_sel ? tx : 1'b1;

    logic [7:0] a_data, b_data;
    logic [4:0] a_count, b_count;
    logic       a_valid, a_fe, a_pe, a_ov, a_to;
    logic       b_valid, b_fe, b_pe, b_ov, b_to;

    uart_rx_fifo dut (
        .comm_clk(clk), .rst_n(rst_n), .rx_serial(rx_a),
        .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rx_ready),
        .fifo_count(a_count), .frame_err(a_fe), .parity_err(a_pe),
        .overrun(a_ov), .rx_timeout(a_to)
    );

    uart_rx_fifo #(.PARITY(2)) dut_even (
        .comm_clk(clk), .rst_n(rst_n), .rx_serial(rx_b),
        .rx_data(b_data), .rx_valid(b_valid), .rx_ready(rx_ready_b),
        .fifo_count(b_count), .frame_err(b_fe), .parity_err(b_pe),
        .overrun(b_ov), .rx_timeout(b_to)
    );

    int checks = 0;
    int failures = 0;

    // Pulse counters, sampled mid-cycle.
    int     n_fe = 0, n_pe = 0, n_ov = 0, n_to = 0, n_multi = 0;
    int     nb_fe = 0, nb_pe = 0, nb_ov = 0;
    longint t_to = 0;

    always @(negedge clk) begin
        if (a_fe) n_fe++;
        if (a_pe) n_pe++;
        if (a_ov) n_ov++;
        if (a_to) begin n_to++; t_to = $time; end
        if (b_fe) nb_fe++;
        if (b_pe) nb_pe++;
        if (b_ov) nb_ov++;
        if (int'(a_fe) + int'(a_pe) + int'(a_ov) > 1) n_multi++;
        if (int'(b_fe) + int'(b_pe) + int'(b_ov) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One character on tx: start, nbits LSB first, optional parity, stop of
    // stop_len time units, then one idle bit. 160 time units per bit.
    task automatic send_frame(input logic [8:0] data, input int nbits, input bit with_par,
                              input logic par, input logic stop_val, input int stop_len);
        tx = 1'b0; #160;
        for (int i = 0; i < nbits; i++) begin
            tx = data[i]; #160;
        end
        if (with_par) begin
            tx = par; #160;
        end
        tx = stop_val; #(stop_len);
        tx = 1'b1; #160;
    endtask

    task automatic send8(input logic [7:0] d);
        send_frame({1'b0, d}, 8, 1'b0, 1'b0, 1'b1, 160);
    endtask

    task automatic pop_a(input logic [7:0] exp, input string tag);
        check({tag, "_valid"}, a_valid, 1);
        check({tag, "_data"}, a_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        longint t0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_count", a_count, 0);
        check("rst_data", a_data, 0);
        check("rst_errs", {a_fe, a_pe, a_ov, a_to}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: two 8N1 characters, no pops in flight
        send8(8'h00);
        send8(8'hA5);
        @(negedge clk);
        check("t1_count", a_count, 2);
        pop_a(8'h00, "t1_pop0");
        pop_a(8'hA5, "t1_pop1");
        check("t1_count_end", a_count, 0);
        check("t1_valid_end", a_valid, 0);
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        check("t1_empty_pop_count", a_count, 0);
        check("t1_errs", n_fe + n_pe + n_ov, 0);

        // 2: 40-unit low glitch on idle line
        tx = 1'b0; #40;
        tx = 1'b1; #400;
        @(negedge clk);
        check("t2_count", a_count, 0);
        check("t2_errs", n_fe + n_pe + n_ov, 0);

        // 3: stop bit held low for two bit-times, then a good character
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 320);
        send8(8'h55);
        @(negedge clk);
        check("t3_frame_err", n_fe, 1);
        check("t3_count", a_count, 1);
        pop_a(8'h55, "t3_pop");
        check("t3_parity_err", n_pe, 0);

        // 4: even parity instance
        tx_sel = 1'b1;
        send_frame(9'h007, 8, 1'b1, 1'b1, 1'b1, 160);
        send_frame(9'h007, 8, 1'b1, 1'b0, 1'b1, 160);
        tx_sel = 1'b0;
        @(negedge clk);
        check("t4_count", b_count, 1);
        check("t4_data", b_data, 8'h07);
        check("t4_parity_err", nb_pe, 1);
        check("t4_frame_err", nb_fe, 0);
        check("t4_other_count", a_count, 0);
        rx_ready_b = 1'b1;
        @(negedge clk);
        rx_ready_b = 1'b0;
        check("t4_count_end", b_count, 0);

        // 5a: 17 characters into a 16-entry FIFO
        for (int i = 1; i <= 17; i++) send8(8'(i));
        @(negedge clk);
        check("t5_count_full", a_count, 16);
        check("t5_overrun", n_ov, 1);
        for (int i = 1; i <= 16; i++) pop_a(8'(i), "t5_pop");
        check("t5_count_empty", a_count, 0);

        // 5b: refill, then pop on the same cycle as the 17th push
        for (int i = 8'h21; i <= 8'h30; i++) send8(8'(i));
        @(negedge clk);
        check("t5b_count_full", a_count, 16);
        fork
            send8(8'h31);
            begin
                #1550;
                check("t5b_pre_count", a_count, 16);
                check("t5b_head", a_data, 8'h21);
                rx_ready = 1'b1;
                #10;
                rx_ready = 1'b0;
                check("t5b_post_count", a_count, 16);
            end
        join
        @(negedge clk);
        check("t5b_overrun", n_ov, 1);
        for (int i = 8'h22; i <= 8'h31; i++) pop_a(8'(i), "t5b_pop");
        check("t5b_count_empty", a_count, 0);

        // 6: reset mid-data-bit 4 with one character already buffered
        send8(8'h99);
        @(negedge clk);
        check("t6_pre_count", a_count, 1);
        fork
            send8(8'h4B);
            begin
                #880;
                rst_n = 1'b0;
            end
        join
        @(negedge clk);
        check("t6_rst_count", a_count, 0);
        check("t6_rst_valid", a_valid, 0);
        check("t6_rst_data", a_data, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send8(8'h81);
        @(negedge clk);
        check("t6_count", a_count, 1);
        pop_a(8'h81, "t6_pop");
        check("t6_frame_err", n_fe, 1);

`ifdef UART_RX_TIMEOUT_EN
        begin
            int     snap;
            longint d;
            snap = n_to;
            t0 = $time;
            send8(8'h08);
            #3400;
            @(negedge clk);
            check("t7_timeout_count", n_to - snap, 1);
            d = t_to - (t0 + 1545);
            check("t7_timeout_time", (d >= 3040 && d <= 3360), 1);
            pop_a(8'h08, "t7_pop");
        end
`else
        t0 = $time;
        check("t7_no_timeout", n_to, 0);
`endif

        check("multi_error_cycles", n_multi, 0);
        check("parity_inst_overrun", nb_ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
